// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Define BIT_SERIAL_OVF_EN to add the signed-overflow output ovf.

module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_axb;

    assign w_axb = i_a ^ i_b;
    assign o_s   = w_axb ^ i_c;
    assign o_c   = (i_a & i_b) | (w_axb & i_c);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BIT_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_s_next;

    full_adder_cell u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    assign w_s_next = {w_s, r_s[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef BIT_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_carry <= w_c;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_s     <= w_s_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        sum     <= w_s_next;
                        cout    <= w_c;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
`ifdef BIT_SERIAL_OVF_EN
                        // r_carry is the carry into the MSB here
                        ovf     <= r_carry ^ w_c;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
